quiz_arbiter: RTL
=================

QUIZ_ARBITER -- requirements
Module: quiz_arbiter

Interface
REQ-001 Parameter ANSWER_TICKS, default 10: clkout cycles allowed for an answer after lock-in.
REQ-002 Parameter SCORE_MAX, default 99: score saturation ceiling, matching the two-digit display.
REQ-003 clkout  input  1  block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn  input  4  player buzzers, active-high, pre-debounced, synchronous to clkout.
REQ-006 host_start, host_correct, host_wrong, host_clear  input  1 each  host commands, single-cycle pulses.
REQ-007 player  output  2  index of the current/last winner, to the display.
REQ-008 score  output  8  score of player, binary 0..SCORE_MAX, to the display.
REQ-009 locked  output  1  high while in state ANSWER.
REQ-010 timeout  output  1  one-cycle pulse when the answer timer expires.
REQ-011 state  output  2  current FSM state encoding.

Function
REQ-012 FSM states: IDLE=0, ARMED=1, ANSWER=2, HOLD=3.
REQ-013 Button events are rising edges: btn registered one cycle; event = btn & ~btn_q.
REQ-014 Host command priority when several are pulsed in one cycle: clear > start > correct > wrong.
REQ-015 host_clear in any state: all four scores = 0, player = 0, next state IDLE, timer = 0.
REQ-016 IDLE/HOLD + host_start -> ARMED; button events in that same cycle are ignored.
REQ-017 ARMED + >=1 button event -> ANSWER next cycle; winner latched into player; timer loaded with ANSWER_TICKS-1.
REQ-018 Simultaneous events: rotating priority; search starts at (last_winner+1) mod 4; last_winner resets to 3, so player 0 has first priority after reset.
REQ-019 In ANSWER, button events are ignored, and no second lock-in occurs.
REQ-020 ANSWER + host_correct: score[player] += 1, saturating at SCORE_MAX; -> HOLD.
REQ-021 ANSWER + host_wrong: score[player] -= 1, saturating at 0; -> HOLD.
REQ-022 ANSWER: timer decrements each cycle; a cycle with timer==0 and no host command -> timeout pulse, score unchanged, -> HOLD.
REQ-023 A host command arriving in the timer==0 cycle wins; no timeout pulse is issued.
REQ-024 host_correct/host_wrong outside ANSWER: ignored.
REQ-025 score output = stored score of the player index, registered; it reflects an update one cycle after the update cycle.
REQ-026 In HOLD, player and score are held until the next host_start or host_clear.
REQ-027 Storage: four 8-bit score registers; arithmetic is unsigned 8-bit, with saturation checked before writeback (no wrap).

Reset
REQ-028 With rst_n low, immediately: state = IDLE, player = 0, score = 0, all score registers = 0, locked = 0, timeout = 0, timer = 0, btn_q = 0, last_winner = 3.
REQ-029 Reset mid-ANSWER aborts the round with no score change committed.
REQ-030 The first clkout edge after reset release samples btn into btn_q only; a button already held at release produces no event.

Configuration
REQ-031 Macro FOUL_PENALTY_EN.
REQ-032 With FOUL_PENALTY_EN defined: a button event in IDLE or HOLD decrements that player's score by 1, saturating at 0.
  - Simultaneous fouls each decrement their own player.
  - player is not changed by a foul.
REQ-033 Without FOUL_PENALTY_EN: button events in IDLE or HOLD are ignored, and no penalty logic is synthesized.

Verification
REQ-034 Reset, host_start, btn=0100 -> state 1 then 2, player=2, locked=1; host_correct -> score=1 one cycle later, state=3.
REQ-035 ARMED, btn=1111 in one cycle with last_winner=3 -> player=0; next round btn=1111 -> player=1.
REQ-036 ANSWER_TICKS=10, lock-in then no command -> timeout pulse exactly 10 cycles after entering ANSWER, score unchanged, state=3.
REQ-037 Score at 99 + host_correct -> stays 99; score at 0 + host_wrong -> stays 0.
REQ-038 FOUL_PENALTY_EN defined: player 1 at score 3 presses in IDLE -> score[1]=2 and state stays 0; macro undefined -> score[1] stays 3.
REQ-039 host_clear and host_correct pulsed together in ANSWER -> all scores 0, state=0.

Source files
------------

// File: rtl/quiz_arbiter.sv
// Quiz-show buzzer arbiter: four buzzers, rotating-priority lock-in, answer
// timer, per-player saturating scores.
// Optional build macro FOUL_PENALTY_EN: a buzzer press while the round is not
// armed (IDLE or HOLD) costs that player one point (saturating at 0).
module quiz_arbiter #(
    parameter int unsigned ANSWER_TICKS = 10,
    parameter int unsigned SCORE_MAX    = 99
) (
    input  logic       clkout,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       host_start,
    input  logic       host_correct,
    input  logic       host_wrong,
    input  logic       host_clear,
    output logic [1:0] player,
    output logic [7:0] score,
    output logic       locked,
    output logic       timeout,
    output logic [1:0] state
);

    localparam int unsigned TW = (ANSWER_TICKS > 1) ? $clog2(ANSWER_TICKS) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(ANSWER_TICKS - 1);
    localparam logic [7:0]    SMAX  = 8'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ANSWER = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        st;
    logic [TW-1:0] timer;
    logic [3:0]    btn_q;
    logic          primed;
    logic [1:0]    last_winner;
    logic [7:0]    scores [4];
    logic [3:0]    ev_c;
    logic [1:0]    win_c;

    assign state = st;

    // Rising-edge detect; masked until btn_q holds a real sample after reset.
    assign ev_c = btn & ~btn_q & {4{primed}};

    // Rotating priority: first event found searching upward from last_winner+1.
    always_comb begin
        win_c = last_winner;
        for (int k = 3; k >= 0; k--) begin
            if (ev_c[2'(last_winner + 2'(k + 1))]) begin
                win_c = 2'(last_winner + 2'(k + 1));
            end
        end
    end

    // Round FSM, timer, score storage and registered display outputs.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            player      <= 2'd0;
            score       <= 8'd0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            timer       <= '0;
            btn_q       <= 4'd0;
            primed      <= 1'b0;
            last_winner <= 2'd3;
            for (int i = 0; i < 4; i++) begin
                scores[i] <= 8'd0;
            end
        end else begin
            btn_q   <= btn;
            primed  <= 1'b1;
            timeout <= 1'b0;
            score   <= scores[player];
            if (host_clear) begin
                for (int i = 0; i < 4; i++) begin
                    scores[i] <= 8'd0;
                end
                player <= 2'd0;
                score  <= 8'd0;
                st     <= IDLE;
                timer  <= '0;
                locked <= 1'b0;
            end else begin
                case (st)
                    IDLE, HOLD: begin
                        if (host_start) begin
                            st <= ARMED;
`ifdef FOUL_PENALTY_EN
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                if (ev_c[i] && scores[i] != 8'd0) begin
                                    scores[i] <= scores[i] - 8'd1;
                                end
                            end
`endif
                        end
                    end
                    ARMED: begin
                        if (|ev_c) begin
                            st          <= ANSWER;
                            player      <= win_c;
                            last_winner <= win_c;
                            timer       <= TLOAD;
                            locked      <= 1'b1;
                        end
                    end
                    ANSWER: begin
                        if (host_correct) begin
                            if (scores[player] < SMAX) begin
                                scores[player] <= scores[player] + 8'd1;
                            end
                            st     <= HOLD;
                            locked <= 1'b0;
                        end else if (host_wrong) begin
                            if (scores[player] != 8'd0) begin
                                scores[player] <= scores[player] - 8'd1;
                            end
                            st     <= HOLD;
                            locked <= 1'b0;
                        end else if (timer == '0) begin
                            timeout <= 1'b1;
                            st      <= HOLD;
                            locked  <= 1'b0;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule
